// File: rtl/seg_pkg.sv
// Shared encodings for the tenths counter: FSM state codes, digit geometry and
// the active-low digit-select patterns.
package seg_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  localparam logic [3:0] SEL_0 = 4'b1110;
  localparam logic [3:0] SEL_1 = 4'b1101;
  localparam logic [3:0] SEL_2 = 4'b1011;
  localparam logic [3:0] SEL_3 = 4'b0111;

  function automatic logic [3:0] digit_sel(input logic [1:0] idx);
    case (idx)
      2'd0:    digit_sel = SEL_0;
      2'd1:    digit_sel = SEL_1;
      2'd2:    digit_sel = SEL_2;
      default: digit_sel = SEL_3;
    endcase
  endfunction

endpackage

// File: rtl/seg_tenths_counter_bcd_digit.sv
// One decade of the BCD count; carry is combinational so a chain of these
// ripples a whole 9999 -> 0000 rollover within a single edge.
module bcd_digit
  import seg_pkg::*;
(
  input  logic               clk_24m,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  assign carry = inc && (digit == 4'd9);

  always_ff @(posedge clk_24m) begin
    if (rst || clr) begin
      digit <= '0;
    end else if (inc) begin
      digit <= (digit == 4'd9) ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/seg_tenths_counter.sv
// Four-digit BCD tenths counter with go/clr run control and a free-running
// digit scanner feeding the single-digit segment decoder.
module seg_tenths_counter
  import seg_pkg::*;
#(
  parameter int CNT_TIME  = 2400_000,
  parameter int SCAN_TIME = 24_000
) (
  input  logic        clk_24m,
  input  logic        rst,
  input  logic        go,
  input  logic        clr,
  output logic        running,
  output logic        wrap,
  output logic [15:0] bcd,
  output logic [3:0]  sm_seg_num,
  output logic [3:0]  sm_bit
);

  localparam int PRE_W  = (CNT_TIME > 1) ? $clog2(CNT_TIME) : 1;
  localparam int SCAN_W = (SCAN_TIME > 1) ? $clog2(SCAN_TIME) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CNT_TIME - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TIME - 1);

  logic [1:0]           state_q;
  logic [1:0]           state_d;
  logic [PRE_W-1:0]     presc_q;
  logic                 tick;
  logic [NUM_DIGITS:0]  inc;
  logic [SCAN_W-1:0]    scan_p0;
  logic [1:0]           idx_p0;

  // clr outranks go; go toggles between RUN and PAUSE, or starts from IDLE
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_IDLE;
    end else if (go) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  assign tick   = (state_q == ST_RUN) && (presc_q == PRE_LAST);
  assign inc[0] = tick && !clr;

  // running decodes the next state so it rises on the same edge that samples go
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      state_q <= ST_IDLE;
      running <= 1'b0;
      wrap    <= 1'b0;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      running <= (state_d == ST_RUN);
      wrap    <= inc[NUM_DIGITS];
      if (clr || state_q == ST_IDLE) begin
        presc_q <= '0;
      end else if (state_q == ST_RUN) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk_24m (clk_24m),
      .rst     (rst),
      .clr     (clr),
      .inc     (inc[g]),
      .digit   (bcd[g*DIGIT_W +: DIGIT_W]),
      .carry   (inc[g+1])
    );
  end

  // scan stage p0: slot timer and digit index
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      scan_p0 <= '0;
      idx_p0  <= 2'd0;
    end else if (scan_p0 == SCAN_LAST) begin
      scan_p0 <= '0;
      idx_p0  <= idx_p0 + 2'd1;
    end else begin
      scan_p0 <= scan_p0 + 1'b1;
    end
  end

  // output stage: digit value and select both taken from the same idx_p0
  always_ff @(posedge clk_24m) begin
    if (rst) begin
      sm_seg_num <= 4'h0;
      sm_bit     <= SEL_0;
    end else begin
      sm_seg_num <= bcd[{idx_p0, 2'b00} +: DIGIT_W];
      sm_bit     <= digit_sel(idx_p0);
    end
  end

endmodule

// File: tb/tb_seg_tenths_counter.sv
// Bench for seg_tenths_counter: fixed vector table, directed corner sequences
// and random go/clr/rst traffic against a decimal-arithmetic reference model.
module tb_seg_tenths_counter;

  localparam int CNT  = 4;
  localparam int SCAN = 2;

  logic        clk_24m = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic        clr = 1'b0;
  logic        running;
  logic        wrap;
  logic [15:0] bcd;
  logic [3:0]  sm_seg_num;
  logic [3:0]  sm_bit;

  int tests = 0;
  int fails = 0;

  seg_tenths_counter #(.CNT_TIME(CNT), .SCAN_TIME(SCAN)) dut (
    .clk_24m    (clk_24m),
    .rst        (rst),
    .go         (go),
    .clr        (clr),
    .running    (running),
    .wrap       (wrap),
    .bcd        (bcd),
    .sm_seg_num (sm_seg_num),
    .sm_bit     (sm_bit)
  );

  always #5 clk_24m = ~clk_24m;

  // Reference model: count as a plain integer 0..9999, mode 0=idle 1=run 2=pause
  int          m_cnt = 0;
  int          m_mode = 0;
  int          m_phase = 0;
  int          m_edges = 0;
  logic        m_wrap = 1'b0;
  logic        m_running = 1'b0;
  logic [3:0]  m_smbit = 4'b1110;
  logic [3:0]  m_segnum = 4'h0;

  function automatic logic [3:0] dec_digit(input int v, input int pos);
    int p;
    p = 1;
    for (int i = 0; i < pos; i++) p = p * 10;
    return 4'((v / p) % 10);
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {dec_digit(v, 3), dec_digit(v, 2), dec_digit(v, 1), dec_digit(v, 0)};
  endfunction

  task automatic model_edge(input logic r, input logic g, input logic c);
    int         pos;
    logic [3:0] one;
    one = 4'b0001;
    if (r) begin
      m_cnt = 0; m_mode = 0; m_phase = 0; m_edges = 0;
      m_wrap = 1'b0; m_running = 1'b0; m_smbit = 4'b1110; m_segnum = 4'h0;
    end else begin
      pos      = (m_edges / SCAN) % 4;
      m_segnum = dec_digit(m_cnt, pos);
      m_smbit  = ~(one << pos);
      m_edges++;
      m_wrap = 1'b0;
      if (c) begin
        m_cnt = 0; m_mode = 0; m_phase = 0;
      end else begin
        if (m_mode == 1) begin
          if (m_phase == CNT - 1) begin
            m_phase = 0;
            if (m_cnt == 9999) begin
              m_cnt = 0; m_wrap = 1'b1;
            end else begin
              m_cnt++;
            end
          end else begin
            m_phase++;
          end
        end
        if (g) m_mode = (m_mode == 1) ? 2 : 1;
      end
      m_running = (m_mode == 1);
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic g, input logic c);
    rst = r; go = g; clr = c;
    @(posedge clk_24m);
    model_edge(r, g, c);
    #1;
    rst = 1'b0; go = 1'b0; clr = 1'b0;
    chk("model_running", 16'(running), 16'(m_running));
    chk("model_wrap", 16'(wrap), 16'(m_wrap));
    chk("model_bcd", bcd, to_bcd(m_cnt));
    chk("model_sm_bit", 16'(sm_bit), 16'(m_smbit));
    chk("model_sm_seg_num", 16'(sm_seg_num), 16'(m_segnum));
  endtask

  typedef struct {
    logic        r;
    logic        g;
    logic        c;
    logic        exp_running;
    logic [15:0] exp_bcd;
    logic        exp_wrap;
  } vec_t;

  vec_t vecs[23];

  initial begin
    int          wraps;
    int          guard;
    logic        saw_9999;
    logic [3:0]  prev_bit;
    logic [3:0]  scan_bits[4];
    logic [3:0]  scan_nums[4];

    scan_bits = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    scan_nums = '{4'h4, 4'h3, 4'h2, 4'h1};

    // reset x3, run/pause/resume, clr+go on a tick, full-length restart
    vecs = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0}
    };

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].r, vecs[i].g, vecs[i].c);
      chk($sformatf("tbl%0d_running", i), 16'(running), 16'(vecs[i].exp_running));
      chk($sformatf("tbl%0d_bcd", i), bcd, vecs[i].exp_bcd);
      chk($sformatf("tbl%0d_wrap", i), 16'(wrap), 16'(vecs[i].exp_wrap));
      if (i == 2) begin
        chk("reset_sm_bit", 16'(sm_bit), 16'h000e);
        chk("reset_sm_seg_num", 16'(sm_seg_num), 16'h0000);
      end
    end

    // Counting: 40 edges of RUN give ten increments
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    chk("count40_bcd", bcd, 16'h0010);
    chk("count40_running", 16'(running), 16'h0001);

    // Pause two edges into a tick at 0003, resume, finish the partial tick
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (bcd != 16'h0003 && guard < 50) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("pause_reach_0003", 16'(guard < 50), 16'h0001);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("pause_running", 16'(running), 16'h0000);
    for (int i = 0; i < 100; i++) step(1'b0, 1'b0, 1'b0);
    chk("pause_hold_bcd", bcd, 16'h0003);
    step(1'b0, 1'b1, 1'b0);
    chk("resume_edge0_bcd", bcd, 16'h0003);
    step(1'b0, 1'b0, 1'b0);
    chk("resume_edge1_bcd", bcd, 16'h0003);
    step(1'b0, 1'b0, 1'b0);
    chk("resume_edge2_bcd", bcd, 16'h0004);

    // Rollover: 40000 RUN edges is exactly 10000 ticks
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    wraps = 0;
    saw_9999 = 1'b0;
    for (int i = 0; i < 40000; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (wrap) wraps++;
      if (bcd == 16'h9999) saw_9999 = 1'b1;
    end
    chk("rollover_saw_9999", 16'(saw_9999), 16'h0001);
    chk("rollover_wrap_count", 16'(wraps), 16'h0001);
    chk("rollover_final_bcd", bcd, 16'h0000);
    chk("rollover_final_wrap", 16'(wrap), 16'h0001);
    step(1'b0, 1'b0, 1'b0);
    chk("rollover_wrap_drop", 16'(wrap), 16'h0000);

    // Scan: pause at 1234 and watch the digit rotation
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    guard = 0;
    while (bcd != 16'h1234 && guard < 6000) begin
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("scan_reach_1234", 16'(guard < 6000), 16'h0001);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    guard = 0;
    prev_bit = sm_bit;
    step(1'b0, 1'b0, 1'b0);
    while (!(sm_bit == 4'b1110 && prev_bit != 4'b1110) && guard < 20) begin
      prev_bit = sm_bit;
      step(1'b0, 1'b0, 1'b0);
      guard++;
    end
    chk("scan_slot0_found", 16'(guard < 20), 16'h0001);
    for (int j = 0; j < 16; j++) begin
      if (j != 0) step(1'b0, 1'b0, 1'b0);
      chk($sformatf("scan%0d_bit", j), 16'(sm_bit), 16'(scan_bits[(j / 2) % 4]));
      chk($sformatf("scan%0d_num", j), 16'(sm_seg_num), 16'(scan_nums[(j / 2) % 4]));
    end
    chk("scan_bcd_held", bcd, 16'h1234);

    // Random control traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 511) == 0), ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
